// File: rtl/packer_pkg.sv
// Shared types and constants for the compression packer scheduler.
package packer_pkg;

    // Words per packer group and width of the in-group index.
    localparam int GROUP_SIZE  = 16;
    localparam int GROUP_IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_KICK    = 3'd2,
        S_WAIT_PK = 3'd3,
        S_NEXT    = 3'd4,
        S_FINISH  = 3'd5
    } sched_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/packer_scheduler.sv
// Packer scheduler: feeds encoded words to the compression packer one at a
// time, pads the last partial group of 16 with zero-mask words, and turns
// packer write strobes/counters into absolute SRAM write addresses.
// Optional build macro PACKER_SCHED_PERF_EN adds saturating performance
// counters (encoder stalls, packer wait cycles, pad words issued).
module packer_scheduler
    import packer_pkg::*;
#(
    parameter int MEM_BW           = 128,
    parameter int ADDR_WIDTH_ACT   = 14,
    parameter int ADDR_WIDTH_MASKS = 11,
    parameter int WORD_CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    // layer configuration
    input  logic                        cfg_start,
    input  logic [WORD_CNT_W-1:0]       cfg_num_words,
    input  logic [ADDR_WIDTH_ACT-1:0]   cfg_act_base,
    input  logic [ADDR_WIDTH_MASKS-1:0] cfg_mask_base,
    output logic                        busy,
    output logic                        done,
    // encoder side
    input  logic                        enc_valid,
    output logic                        enc_ready,
    // packer side
    output logic                        pad_word,
    output logic                        start_packer,
    input  logic                        ready_packer,
    output logic [GROUP_IDX_W-1:0]      encoder_to_packer_counter,
    input  logic                        packer_write_control,
    input  logic                        write_activations_memory_extra,
    input  logic                        write_masks_memory_extra,
    input  logic [ADDR_WIDTH_ACT-1:0]   outputs_encoded_to_memory_counter,
    input  logic [ADDR_WIDTH_MASKS-1:0] outputs_masks_to_memory_counter,
    // SRAM write side
    output logic [ADDR_WIDTH_ACT-1:0]   act_wr_addr,
    output logic [ADDR_WIDTH_MASKS-1:0] mask_wr_addr,
    output logic                        act_we,
    output logic                        mask_we
`ifdef PACKER_SCHED_PERF_EN
    ,
    output logic [31:0]                 perf_stall_enc,
    output logic [31:0]                 perf_wait_pk,
    output logic [31:0]                 perf_pad
`endif
);

    // The SRAM data path is not routed through here; the width only has to
    // describe a byte-addressable word.
    if (MEM_BW % 8 != 0) begin : g_bad_mem_bw
        $error("packer_scheduler: MEM_BW must be a multiple of 8");
    end

    localparam logic [GROUP_IDX_W-1:0] LAST_IDX = GROUP_IDX_W'(GROUP_SIZE - 1);

    sched_state_t                state_q, state_d;
    logic [GROUP_IDX_W-1:0]      counter_q, counter_d;
    logic [WORD_CNT_W-1:0]       remaining_q, remaining_d;
    logic                        busy_q, busy_d;
    logic                        pad_q, pad_d;
    logic [ADDR_WIDTH_ACT-1:0]   act_base_q, act_base_d;
    logic [ADDR_WIDTH_MASKS-1:0] mask_base_q, mask_base_d;

    // Next-state and one-cycle strobe decode.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        remaining_d  = remaining_q;
        busy_d       = busy_q;
        pad_d        = pad_q;
        act_base_d   = act_base_q;
        mask_base_d  = mask_base_q;
        enc_ready    = 1'b0;
        start_packer = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    act_base_d  = cfg_act_base;
                    mask_base_d = cfg_mask_base;
                    remaining_d = cfg_num_words;
                    counter_d   = '0;
                    pad_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = (cfg_num_words == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (remaining_q != '0) begin
                    if (enc_valid) begin
                        enc_ready   = 1'b1;
                        remaining_d = remaining_q - WORD_CNT_W'(1);
                        state_d     = S_KICK;
                    end
                end else if (counter_q != '0) begin
                    // Encoder is drained mid-group: fill the group with
                    // zero-mask words so the packer can flush it.
                    pad_d   = 1'b1;
                    state_d = S_KICK;
                end else begin
                    // Nothing left and on a group boundary; not reachable in
                    // normal operation, but never strand the layer.
                    state_d = S_FINISH;
                end
            end
            S_KICK: begin
                start_packer = 1'b1;
                state_d      = S_WAIT_PK;
            end
            S_WAIT_PK: begin
                if (ready_packer) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                pad_d = 1'b0;
                if (counter_q == LAST_IDX) begin
                    counter_d = '0;
                    state_d   = (remaining_q == '0) ? S_FINISH : S_FETCH;
                end else begin
                    counter_d = counter_q + GROUP_IDX_W'(1);
                    state_d   = S_FETCH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scheduler state and latched layer configuration.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= S_IDLE;
            counter_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            pad_q       <= 1'b0;
            act_base_q  <= '0;
            mask_base_q <= '0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            pad_q       <= pad_d;
            act_base_q  <= act_base_d;
            mask_base_q <= mask_base_d;
        end
    end

    assign busy                      = busy_q;
    assign pad_word                  = pad_q;
    assign encoder_to_packer_counter = counter_q;

    // Absolute SRAM addresses; the sums wrap at the address width.
    assign act_wr_addr  = act_base_q + outputs_encoded_to_memory_counter;
    assign mask_wr_addr = mask_base_q + outputs_masks_to_memory_counter;

    // The packer's per-memory requests are active low.
    assign act_we  = packer_write_control & ~write_activations_memory_extra;
    assign mask_we = packer_write_control & ~write_masks_memory_extra;

`ifdef PACKER_SCHED_PERF_EN
    logic        perf_clear;
    logic        stall_evt;
    logic        wait_evt;
    logic        pad_evt;
    logic [31:0] stall_q, wait_q, pad_cnt_q;

    assign perf_clear = (state_q == S_IDLE) && cfg_start;
    assign stall_evt  = (state_q == S_FETCH) && (remaining_q != '0) && !enc_valid;
    assign wait_evt   = (state_q == S_WAIT_PK);
    assign pad_evt    = (state_q == S_FETCH) && (remaining_q == '0) && (counter_q != '0);

    // Saturating performance counters, cleared when a layer is accepted.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            stall_q   <= '0;
            wait_q    <= '0;
            pad_cnt_q <= '0;
        end else if (perf_clear) begin
            stall_q   <= '0;
            wait_q    <= '0;
            pad_cnt_q <= '0;
        end else begin
            if (stall_evt) stall_q   <= sat_inc32(stall_q);
            if (wait_evt)  wait_q    <= sat_inc32(wait_q);
            if (pad_evt)   pad_cnt_q <= sat_inc32(pad_cnt_q);
        end
    end

    assign perf_stall_enc = stall_q;
    assign perf_wait_pk   = wait_q;
    assign perf_pad       = pad_cnt_q;
`endif

endmodule

// File: tb/tb_packer_scheduler.sv
// Self-checking bench for packer_scheduler. A layer model lists the kicks a
// layer must produce (group index and pad flag per kick); a monitor compares
// each start_packer against it and watches handshake rules every cycle.
module tb_packer_scheduler;

    logic        clk;
    logic        arst_n_in;
    logic        cfg_start;
    logic [15:0] cfg_num_words;
    logic [13:0] cfg_act_base;
    logic [10:0] cfg_mask_base;
    logic        busy;
    logic        done;
    logic        enc_valid;
    logic        enc_ready;
    logic        pad_word;
    logic        start_packer;
    logic        ready_packer;
    logic [3:0]  encoder_to_packer_counter;
    logic        packer_write_control;
    logic        write_activations_memory_extra;
    logic        write_masks_memory_extra;
    logic [13:0] outputs_encoded_to_memory_counter;
    logic [10:0] outputs_masks_to_memory_counter;
    logic [13:0] act_wr_addr;
    logic [10:0] mask_wr_addr;
    logic        act_we;
    logic        mask_we;
`ifdef PACKER_SCHED_PERF_EN
    logic [31:0] perf_stall_enc;
    logic [31:0] perf_wait_pk;
    logic [31:0] perf_pad;
`endif

    packer_scheduler dut (
        .clk                               (clk),
        .arst_n_in                         (arst_n_in),
        .cfg_start                         (cfg_start),
        .cfg_num_words                     (cfg_num_words),
        .cfg_act_base                      (cfg_act_base),
        .cfg_mask_base                     (cfg_mask_base),
        .busy                              (busy),
        .done                              (done),
        .enc_valid                         (enc_valid),
        .enc_ready                         (enc_ready),
        .pad_word                          (pad_word),
        .start_packer                      (start_packer),
        .ready_packer                      (ready_packer),
        .encoder_to_packer_counter         (encoder_to_packer_counter),
        .packer_write_control              (packer_write_control),
        .write_activations_memory_extra    (write_activations_memory_extra),
        .write_masks_memory_extra          (write_masks_memory_extra),
        .outputs_encoded_to_memory_counter (outputs_encoded_to_memory_counter),
        .outputs_masks_to_memory_counter   (outputs_masks_to_memory_counter),
        .act_wr_addr                       (act_wr_addr),
        .mask_wr_addr                      (mask_wr_addr),
        .act_we                            (act_we),
        .mask_we                           (mask_we)
`ifdef PACKER_SCHED_PERF_EN
        ,
        .perf_stall_enc                    (perf_stall_enc),
        .perf_wait_pk                      (perf_wait_pk),
        .perf_pad                          (perf_pad)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Layer model: one entry per expected kick.
    typedef struct packed {
        logic [3:0] idx;
        logic       pad;
    } kick_t;

    kick_t exp_q[$];
    int    exp_total;
    int    kicks_seen;
    int    pads_seen;
    int    enc_seen;
    int    done_seen;
    int    busy_cycles;
    int    starts_total;
    bit    check_en;
    bit    prev_enc_ready;
    bit    outstanding;
    int    enc_mode;      // 0: enc_valid always high, 1: toggles every cycle

    // Builds the expected kick list straight from the word count: groups of
    // 16, real words first, zero-mask pads fill the last partial group.
    task automatic build_model(input int n);
        kick_t k;
        exp_q.delete();
        exp_total = ((n + 15) / 16) * 16;
        for (int i = 0; i < exp_total; i++) begin
            k.idx = 4'(i % 16);
            k.pad = (i >= n);
            exp_q.push_back(k);
        end
        kicks_seen     = 0;
        pads_seen      = 0;
        enc_seen       = 0;
        done_seen      = 0;
        busy_cycles    = 0;
        prev_enc_ready = 1'b0;
        outstanding    = 1'b0;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        kick_t k;
        if (start_packer) starts_total++;
        if (check_en) begin
            if (busy) busy_cycles++;
            if (!busy) check("idle_quiet", {30'd0, start_packer, enc_ready}, 32'd0);
            if (enc_ready) begin
                enc_seen++;
                check("enc_ready_without_valid", enc_valid, 1'b1);
            end
            if (start_packer) begin
                kicks_seen++;
                if (pad_word) pads_seen++;
                check("start_while_packer_busy", outstanding, 1'b0);
                check("kick_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    k = exp_q.pop_front();
                    check("kick_group_index", encoder_to_packer_counter, k.idx);
                    check("kick_pad_word", pad_word, k.pad);
                    check("kick_one_cycle_after_enc_ready", prev_enc_ready, !k.pad);
                end
                outstanding = 1'b1;
            end
            if (ready_packer) outstanding = 1'b0;
            if (done) done_seen++;
            prev_enc_ready = enc_ready;
        end
    end

    // Packer model (ready 3 cycles after each start) and encoder valid pattern.
    int pk_delay;
    int pk_last;
    always begin
        @(posedge clk);
        #1;
        ready_packer = 1'b0;
        if (starts_total != pk_last) begin
            pk_last  = starts_total;
            pk_delay = 3;
        end
        if (pk_delay > 0) begin
            pk_delay--;
            if (pk_delay == 0) ready_packer = 1'b1;
        end
        if (enc_mode == 1) enc_valid = ~enc_valid;
        else               enc_valid = 1'b1;
    end

    task automatic pulse_cfg(input int n, input logic [13:0] ab, input logic [10:0] mb);
        @(posedge clk);
        #1;
        cfg_num_words = 16'(n);
        cfg_act_base  = ab;
        cfg_mask_base = mb;
        cfg_start     = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic start_layer(input int n, input logic [13:0] ab, input logic [10:0] mb);
        build_model(n);
        check_en = 1'b1;
        pulse_cfg(n, ab, mb);
    endtask

    task automatic finish_layer(input string tag, input int n);
        for (int i = 0; i < 3000 && done_seen == 0; i++) @(negedge clk);
        check({tag, "_done_timeout"}, done_seen != 0, 1'b1);
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_seen, 1);
        check({tag, "_kicks"}, kicks_seen, exp_total);
        check({tag, "_enc_ready_count"}, enc_seen, n);
        check({tag, "_pads"}, pads_seen, exp_total - n);
        check({tag, "_model_drained"}, exp_q.size(), 0);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        starts_total = 0;
        pk_last = 0;
        pk_delay = 0;
        check_en = 1'b0;
        enc_mode = 0;
        arst_n_in = 1'b0;
        cfg_start = 1'b0;
        cfg_num_words = '0;
        cfg_act_base = '0;
        cfg_mask_base = '0;
        enc_valid = 1'b0;
        ready_packer = 1'b0;
        packer_write_control = 1'b0;
        write_activations_memory_extra = 1'b1;
        write_masks_memory_extra = 1'b1;
        outputs_encoded_to_memory_counter = '0;
        outputs_masks_to_memory_counter = '0;
        build_model(0);

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pad_word", pad_word, 1'b0);
        check("rst_counter", encoder_to_packer_counter, 4'd0);
        check("rst_start_packer", start_packer, 1'b0);
        check("rst_enc_ready", enc_ready, 1'b0);
        check("rst_act_wr_addr", act_wr_addr, 14'd0);
        arst_n_in = 1'b1;

        // Full group of 16: no padding; a cfg_start mid-layer is ignored.
        enc_mode = 0;
        start_layer(16, 14'h0100, 11'h010);
        repeat (20) @(posedge clk);
        #1;
        cfg_num_words = 16'd3;
        cfg_act_base  = 14'h2000;
        cfg_mask_base = 11'h400;
        cfg_start     = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        finish_layer("w16", 16);
        check("w16_kicks_literal", kicks_seen, 16);
        check("w16_pads_literal", pads_seen, 0);
        #1;
        outputs_encoded_to_memory_counter = 14'h0020;
        outputs_masks_to_memory_counter   = 11'h007;
        #1;
        check("w16_act_addr_orig_base", act_wr_addr, 14'h0120);
        check("w16_mask_addr_orig_base", mask_wr_addr, 11'h017);

        // 17 words: one real word in the second group plus 15 pads.
        start_layer(17, 14'h3FFE, 11'h7FD);
        finish_layer("w17", 17);
        check("w17_kicks_literal", kicks_seen, 32);
        check("w17_pads_literal", pads_seen, 15);
`ifdef PACKER_SCHED_PERF_EN
        check("w17_perf_pad", perf_pad, 32'd15);
        check("w17_perf_wait_pk", perf_wait_pk, 32'd96);
        check("w17_perf_stall", perf_stall_enc, 32'd0);
`endif

        // Address wrap and write-enable decode.
        #1;
        outputs_encoded_to_memory_counter = 14'd3;
        outputs_masks_to_memory_counter   = 11'd5;
        packer_write_control              = 1'b1;
        write_masks_memory_extra          = 1'b0;
        write_activations_memory_extra    = 1'b1;
        #1;
        check("act_addr_wrap", act_wr_addr, 14'h0001);
        check("mask_addr_wrap", mask_wr_addr, 11'h002);
        check("mask_we_low_req", mask_we, 1'b1);
        check("act_we_held_off", act_we, 1'b0);
        write_activations_memory_extra = 1'b0;
        #1;
        check("act_we_both", act_we, 1'b1);
        check("mask_we_both", mask_we, 1'b1);
        packer_write_control = 1'b0;
        #1;
        check("we_no_strobe", {30'd0, act_we, mask_we}, 32'd0);
        write_activations_memory_extra = 1'b1;
        write_masks_memory_extra       = 1'b1;
        outputs_encoded_to_memory_counter = '0;
        outputs_masks_to_memory_counter   = '0;

        // Empty layer: one busy cycle, one done, no kicks.
        start_layer(0, 14'h0000, 11'h000);
        finish_layer("w0", 0);
        check("w0_busy_cycles", busy_cycles, 1);
        check("w0_kicks_literal", kicks_seen, 0);

        // Encoder valid toggling, 5 words then 11 pads.
        enc_mode = 1;
        start_layer(5, 14'h0040, 11'h020);
        finish_layer("w5", 5);
        check("w5_pads_literal", pads_seen, 11);
        enc_mode = 0;

        // Reset while waiting on the packer at group index 7.
        start_layer(16, 14'h0000, 11'h000);
        begin
            int i;
            for (i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (start_packer && encoder_to_packer_counter == 4'd7) break;
            end
            check("rst_mid_reach_idx7", i < 2000, 1'b1);
        end
        @(posedge clk);
        #2;
        check_en  = 1'b0;
        arst_n_in = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_counter", encoder_to_packer_counter, 4'd0);
        check("rst_mid_pad_start", {30'd0, pad_word, start_packer}, 32'd0);
        check("rst_mid_done_ready", {30'd0, done, enc_ready}, 32'd0);
        check("rst_mid_addr_we", {act_wr_addr, mask_wr_addr, act_we, mask_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        repeat (8) @(posedge clk);
        start_layer(16, 14'h0010, 11'h001);
        finish_layer("restart", 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/packer_scheduler.md
Name: packer_scheduler

Overview:
- Sequences the compression packer for one layer: hands encoded words from the encoder to the packer one at a time and drives the 0..15 group index (encoder_to_packer_counter).
- Pads the final partial group of 16 with zero-mask words and translates packer write strobes/counters into absolute SRAM write addresses.
- Sits between the encoder output stage and the activation/mask SRAM write ports; the top-level controller configures it once per layer.

Parameters:
- MEM_BW, 128, SRAM word width (pass-through sizing only)
- ADDR_WIDTH_ACT, 14, activation SRAM address width
- ADDR_WIDTH_MASKS, 11, mask SRAM address width
- WORD_CNT_W, 16, width of the per-layer word count

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- cfg_start  in  1  one-cycle pulse; latches cfg_* and starts a layer
- cfg_num_words  in  WORD_CNT_W  encoded words in this layer; 0 is legal
- cfg_act_base  in  ADDR_WIDTH_ACT  activation SRAM base address
- cfg_mask_base  in  ADDR_WIDTH_MASKS  mask SRAM base address
- busy  out  1  layer in progress
- done  out  1  one-cycle pulse when the layer completes
- enc_valid  in  1  encoder has a word (masks_in/encoded_in) available
- enc_ready  out  1  word consumed this cycle
- pad_word  out  1  current packer input must be forced to masks=0, data=0
- start_packer  out  1  kick to packer
- ready_packer  in  1  packer finished the current word
- encoder_to_packer_counter  out  4  group index of the current word
- packer_write_control  in  1  packer write strobe
- write_activations_memory_extra  in  1  active-low activation write request
- write_masks_memory_extra  in  1  active-low mask write request
- outputs_encoded_to_memory_counter  in  ADDR_WIDTH_ACT  packer activation write index
- outputs_masks_to_memory_counter  in  ADDR_WIDTH_MASKS  packer mask write index
- act_wr_addr  out  ADDR_WIDTH_ACT  cfg_act_base + outputs_encoded_to_memory_counter, mod 2^ADDR_WIDTH_ACT
- mask_wr_addr  out  ADDR_WIDTH_MASKS  cfg_mask_base + outputs_masks_to_memory_counter, mod 2^ADDR_WIDTH_MASKS
- act_we  out  1  packer_write_control & ~write_activations_memory_extra, combinational
- mask_we  out  1  packer_write_control & ~write_masks_memory_extra, combinational

Behaviour:
- Reset values: all outputs 0, including counter, busy, done and pad_word; state IDLE; remaining-word counter 0. Reset mid-layer abandons the layer; no done pulse is produced.
- States: IDLE, FETCH, KICK, WAIT_PK, NEXT, FINISH.
- IDLE:
  - cfg_start latches the config, clears counter := 0, sets busy.
  - Next state is FETCH, or FINISH when cfg_num_words == 0.
- FETCH:
  - If remaining > 0 and enc_valid: assert enc_ready for one cycle, remaining -= 1, go to KICK.
  - If remaining == 0 and counter != 0: set pad_word = 1, go to KICK without asserting enc_ready.
  - If remaining > 0 and !enc_valid: wait.
- KICK: start_packer = 1 for exactly one cycle; go to WAIT_PK.
- WAIT_PK:
  - Hold counter and pad_word stable.
  - ready_packer seen → NEXT.
  - A ready_packer pulse in any other state is ignored.
- NEXT:
  - Counter == 15: counter := 0 (the packer has flushed the group); go to FETCH, or FINISH when remaining == 0.
  - Otherwise counter += 1, then FETCH.
  - pad_word clears when leaving NEXT.
- FINISH: done = 1 for one cycle; busy := 0; go to IDLE.
- Latency: enc_ready to start_packer is exactly 1 cycle. start_packer is never issued while the packer is between start_packer and ready_packer.
- Boundary cases:
  - cfg_num_words = 16: no padding.
  - cfg_num_words = 17: 1 real word plus 15 pad words.
  - cfg_start while busy: ignored.
  - Address addition wraps silently.
  - act_we and mask_we may assert in the same cycle.

Optional Feature:
- Macro: PACKER_SCHED_PERF_EN.
- When defined, three saturating 32-bit counters are added, cleared on cfg_start:
  - stall_enc_cycles: FETCH with remaining > 0 and !enc_valid.
  - wait_pk_cycles: cycles spent in WAIT_PK.
  - pad_words: pad words issued.
- They are exposed as outputs perf_stall_enc, perf_wait_pk and perf_pad.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package packer_pkg holds:
  - sched_state_t enum.
  - GROUP_SIZE = 16 and GROUP_IDX_W = 4.
- No sub-module is needed; the address adders stay inline.

Test Plan:
- cfg_num_words=16, enc_valid constantly high, packer model returns ready_packer 3 cycles after start → 16 start pulses, counter 0..15, no pad_word, done once, busy low afterwards.
- cfg_num_words=17 → 17 enc_ready pulses total, then 15 kicks with pad_word=1 and counter 1..15, then done.
- cfg_num_words=0 → busy for 1 cycle, done pulse, zero start_packer pulses.
- enc_valid toggling every other cycle → enc_ready only when enc_valid=1; start_packer always 1 cycle after enc_ready.
- cfg_act_base=0x3FFE, packer counter=3 → act_wr_addr=0x0001; packer_write_control=1 with write_masks_memory_extra=0 → mask_we=1 and act_we follows write_activations_memory_extra.
- arst_n_in low in WAIT_PK at counter=7 → all outputs 0 immediately; a new cfg_start restarts at counter 0.
